// File: rtl/id_ex_issue.sv
// id_ex_issue: decodes the IF/ID instruction into the ID/EX register, stalls load-use hazards and honours flush.
module id_ex_issue #(
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic [NB_INST-1:0] i_pc,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [NB_INST-1:0] o_pc,
  output logic [NB_INST-1:0] o_sign_extend,
  output logic [NB_DATA-1:0] o_data_1,
  output logic [NB_DATA-1:0] o_data_2,
  output logic [NB_OP-1:0]   o_code,
  output logic               o_selector_mux_A,
  output logic               o_selector_mux_B,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_illegal
);
  typedef struct packed {
    logic               valid;
    logic [NB_INST-1:0] pc;
    logic [NB_INST-1:0] sign_extend;
    logic [NB_DATA-1:0] data_1;
    logic [NB_DATA-1:0] data_2;
    logic [NB_OP-1:0]   code;
    logic               mux_a;
    logic               mux_b;
    logic [NB_REG-1:0]  reg_dst;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } ex_t;
  ex_t ex_d, ex_q;
  logic illegal_d, illegal_q;
  logic [5:0] opcode, funct;
  logic [4:0] shamt;
  logic [15:0] imm;
  logic [NB_REG-1:0] rs, rt, rd;
  logic [NB_INST-1:0] sext, zext, shext;
  logic legal, uses_rt, hazard, dec_mux_b, dec_rw, dec_mr, dec_mw;
  logic [NB_OP-1:0] dec_code;
  logic [NB_REG-1:0] dec_dst;
  logic [NB_INST-1:0] dec_se;
  assign opcode = i_instruction[31:26];
  assign rs     = i_instruction[21 +: NB_REG];
  assign rt     = i_instruction[16 +: NB_REG];
  assign rd     = i_instruction[11 +: NB_REG];
  assign shamt  = i_instruction[10:6];
  assign funct  = i_instruction[5:0];
  assign imm    = i_instruction[15:0];
  assign sext   = {{(NB_INST-16){imm[15]}}, imm};
  assign zext   = {{(NB_INST-16){1'b0}}, imm};
  assign shext  = {{(NB_INST-5){1'b0}}, shamt};
  always_comb begin
    legal     = 1'b1;
    dec_code  = NB_OP'(6'b100000);
    dec_mux_b = 1'b1;
    dec_dst   = rt;
    dec_rw    = 1'b1;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_se    = sext;
    case (opcode)
      6'b000000: begin
        dec_code  = NB_OP'(funct);
        dec_mux_b = 1'b0;
        dec_dst   = rd;
        dec_rw    = i_instruction != '0;
        dec_se    = (funct[5:2] == 4'b0000 && funct != 6'b000001) ? shext : sext;
      end
      6'b001000: ;
      6'b001100: begin dec_code = NB_OP'(6'b100100); dec_se = zext; end
      6'b001101: begin dec_code = NB_OP'(6'b100101); dec_se = zext; end
      6'b001110: begin dec_code = NB_OP'(6'b100110); dec_se = zext; end
      6'b001010: dec_code = NB_OP'(6'b101010);
      6'b100011: begin dec_code = NB_OP'(6'b100001); dec_mr = 1'b1; end
      6'b101011: begin dec_code = NB_OP'(6'b100001); dec_rw = 1'b0; dec_mw = 1'b1; dec_dst = '0; end
      default:   legal = 1'b0;
    endcase
  end
  assign uses_rt = opcode == 6'b000000 || opcode == 6'b101011;
  assign hazard  = i_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_dst != '0 &&
                   (rs == ex_q.reg_dst || (uses_rt && rt == ex_q.reg_dst));
  assign o_ready = i_flush || !hazard;
  always_comb begin
    ex_d      = '0;
    illegal_d = 1'b0;
    if (!i_flush && !hazard && i_valid) begin
      illegal_d = !legal;
      if (legal) begin
        ex_d.valid       = 1'b1;
        ex_d.pc          = i_pc;
        ex_d.sign_extend = dec_se;
        ex_d.data_1      = i_rs_data;
        ex_d.data_2      = i_rt_data;
        ex_d.code        = dec_code;
        ex_d.mux_b       = dec_mux_b;
        ex_d.reg_dst     = dec_dst;
        ex_d.reg_write   = dec_rw;
        ex_d.mem_read    = dec_mr;
        ex_d.mem_write   = dec_mw;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      illegal_q <= illegal_d;
    end
  end
  assign o_valid          = ex_q.valid;
  assign o_pc             = ex_q.pc;
  assign o_sign_extend    = ex_q.sign_extend;
  assign o_data_1         = ex_q.data_1;
  assign o_data_2         = ex_q.data_2;
  assign o_code           = ex_q.code;
  assign o_selector_mux_A = ex_q.mux_a;
  assign o_selector_mux_B = ex_q.mux_b;
  assign o_reg_dst        = ex_q.reg_dst;
  assign o_reg_write      = ex_q.reg_write;
  assign o_mem_read       = ex_q.mem_read;
  assign o_mem_write      = ex_q.mem_write;
  assign o_illegal        = illegal_q;
endmodule
